// File: rtl/ws2812_pkg.sv
// Shared constants and FSM state type for the WS2812 receive path.
// Default timing assumes a 100 MHz clock.
package ws2812_pkg;

    localparam int CLK_MHZ        = 100;
    localparam int T0H            = 40;
    localparam int T1H            = 80;
    localparam int T_MIN_HIGH_DEF = 10;
    localparam int T_THRESH_DEF   = (T0H + T1H) / 2;
    localparam int T_MAX_HIGH_DEF = 200;
    localparam int T_RESET_DEF    = 50 * CLK_MHZ;
    localparam int LED_COUNT_DEF  = 52;
    localparam int PX_IDX_W_DEF   = 6;
    localparam int BITS_PER_PIXEL = 24;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } rx_state_t;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Brings the asynchronous WS2812 line into the clk domain and produces
// registered rise/fall strobes aligned with the synchronised level din_s.
module ws2812_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;

    // NOTE: meta_q may be metastable; nothing but sync_q may ever sample it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            din_s  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            din_s  <= sync_q;
            rise   <= sync_q & ~din_s;
            fall   <= ~sync_q & din_s;
        end
    end

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 single-wire receiver: measures high/low times, rebuilds 24-bit GRB words
// and frame boundaries. Optional counters frame_cnt/err_cnt under WS2812_RX_STATS_EN.
module ws2812_rx_decoder
    import ws2812_pkg::*;
#(
    parameter int T_MIN_HIGH = T_MIN_HIGH_DEF,
    parameter int T_THRESH   = T_THRESH_DEF,
    parameter int T_MAX_HIGH = T_MAX_HIGH_DEF,
    parameter int T_RESET    = T_RESET_DEF,
    parameter int LED_COUNT  = LED_COUNT_DEF,
    parameter int PX_IDX_W   = PX_IDX_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                din,
    output logic [23:0]         pixel_data,
    output logic                pixel_valid,
    output logic [PX_IDX_W-1:0] pixel_idx,
    output logic                frame_done,
    output logic [PX_IDX_W:0]   frame_px,
    output logic                busy,
    output logic                err_glitch,
    output logic                err_partial,
    output logic                err_overrun,
    input  logic                err_clr
`ifdef WS2812_RX_STATS_EN
    ,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         err_cnt
`endif
);

    localparam int HCNT_W = $clog2(T_MAX_HIGH + 2);
    localparam int LCNT_W = $clog2(T_RESET + 1);
    localparam int BCNT_W = $clog2(BITS_PER_PIXEL);
    localparam int PCNT_W = PX_IDX_W + 1;

    localparam logic [HCNT_W-1:0] H_MIN    = HCNT_W'(T_MIN_HIGH);
    localparam logic [HCNT_W-1:0] H_THRESH = HCNT_W'(T_THRESH);
    localparam logic [HCNT_W-1:0] H_MAX    = HCNT_W'(T_MAX_HIGH);
    localparam logic [LCNT_W-1:0] L_LATCH  = LCNT_W'(T_RESET);
    localparam logic [BCNT_W-1:0] B_LAST   = BCNT_W'(BITS_PER_PIXEL - 1);
    localparam logic [PCNT_W-1:0] P_MAX    = PCNT_W'(LED_COUNT);

    logic din_s;
    logic rise;
    logic fall;

    ws2812_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (din),
        .din_s   (din_s),
        .rise    (rise),
        .fall    (fall)
    );

    rx_state_t         state;
    logic [HCNT_W-1:0] hcnt;
    logic [LCNT_W-1:0] lcnt;
    logic [BCNT_W-1:0] bcnt;
    logic [PCNT_W-1:0] pcnt;
    logic [23:0]       sreg;
    logic              err_evt;

    logic              pulse_bad;
    logic              bit_val;
    logic [23:0]       sreg_next;

    // hcnt equals the exact high width (in clk cycles) on the cycle fall is seen.
    always_comb begin
        pulse_bad = (hcnt < H_MIN) || (hcnt > H_MAX);
        bit_val   = (hcnt >= H_THRESH);
        sreg_next = {sreg[22:0], bit_val};
    end

    // NOTE: every flop is reset, including sreg; a reset mid-frame must not leak old bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SYNC;
            hcnt        <= '0;
            lcnt        <= '0;
            bcnt        <= '0;
            pcnt        <= '0;
            sreg        <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_idx   <= '0;
            frame_done  <= 1'b0;
            frame_px    <= '0;
            busy        <= 1'b0;
            err_glitch  <= 1'b0;
            err_partial <= 1'b0;
            err_overrun <= 1'b0;
            err_evt     <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err_evt     <= 1'b0;
            // NOTE: the clear comes first so a same-cycle error assignment below overrides it.
            if (err_clr) begin
                err_glitch  <= 1'b0;
                err_partial <= 1'b0;
                err_overrun <= 1'b0;
            end

            case (state)
                SYNC: begin
                    if (din_s) begin
                        lcnt <= '0;
                    end else if (lcnt == L_LATCH) begin
                        state <= IDLE;
                        lcnt  <= '0;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end

                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        hcnt  <= HCNT_W'(1);
                        busy  <= 1'b1;
                    end
                end

                HIGH: begin
                    if ((fall && pulse_bad) || (!fall && hcnt > H_MAX)) begin
                        // A bad pulse abandons the whole frame and forces a fresh latch.
                        state      <= SYNC;
                        err_glitch <= 1'b1;
                        err_evt    <= 1'b1;
                        bcnt       <= '0;
                        pcnt       <= '0;
                        lcnt       <= '0;
                        busy       <= 1'b0;
                    end else if (fall) begin
                        state <= LOW;
                        lcnt  <= LCNT_W'(1);
                        sreg  <= sreg_next;
                        if (bcnt == B_LAST) begin
                            bcnt <= '0;
                            if (pcnt == P_MAX) begin
                                err_overrun <= 1'b1;
                                err_evt     <= 1'b1;
                            end else begin
                                pixel_valid <= 1'b1;
                                pixel_data  <= sreg_next;
                                pixel_idx   <= pcnt[PX_IDX_W-1:0];
                                pcnt        <= pcnt + 1'b1;
                            end
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end

                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                        hcnt  <= HCNT_W'(1);
                    end else if (lcnt == L_LATCH) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        bcnt  <= '0;
                        pcnt  <= '0;
                        if (pcnt != '0 || bcnt != '0) begin
                            frame_done <= 1'b1;
                            frame_px   <= pcnt;
                        end
                        if (bcnt != '0) begin
                            err_partial <= 1'b1;
                            err_evt     <= 1'b1;
                        end
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end

                default: state <= SYNC;
            endcase
        end
    end

`ifdef WS2812_RX_STATS_EN
    // Counters follow the registered strobes, one cycle after the event itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            frame_cnt <= (err_clr ? 16'd0 : frame_cnt) + {15'd0, frame_done};
            err_cnt   <= (err_clr ? 16'd0 : err_cnt) + {15'd0, err_evt};
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder: drives pulse trains, predicts pixels,
// frames and sticky errors with a bit-level model and compares every strobe.
module tb_ws2812_rx_decoder;

    localparam int T_MIN     = 10;
    localparam int T_TH      = 60;
    localparam int T_MAX     = 200;
    localparam int T_RST     = 500;
    localparam int LEDS      = 52;
    localparam int IDXW      = 6;
    localparam int LATCH_LOW = 600;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            din;
    logic            err_clr;
    logic [23:0]     pixel_data;
    logic            pixel_valid;
    logic [IDXW-1:0] pixel_idx;
    logic            frame_done;
    logic [IDXW:0]   frame_px;
    logic            busy;
    logic            err_glitch;
    logic            err_partial;
    logic            err_overrun;
`ifdef WS2812_RX_STATS_EN
    logic [15:0]     frame_cnt;
    logic [15:0]     err_cnt;
`endif

    always #5 clk = ~clk;

    ws2812_rx_decoder #(
        .T_MIN_HIGH (T_MIN),
        .T_THRESH   (T_TH),
        .T_MAX_HIGH (T_MAX),
        .T_RESET    (T_RST),
        .LED_COUNT  (LEDS),
        .PX_IDX_W   (IDXW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_idx   (pixel_idx),
        .frame_done  (frame_done),
        .frame_px    (frame_px),
        .busy        (busy),
        .err_glitch  (err_glitch),
        .err_partial (err_partial),
        .err_overrun (err_overrun),
        .err_clr     (err_clr)
`ifdef WS2812_RX_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: one entry per pulse, decided purely from its measured width.
    logic [23:0] exp_px_q[$];
    int          exp_idx_q[$];
    int          exp_fr_q[$];
    bit          m_synced;
    int          m_bits;
    logic [23:0] m_word;
    int          m_pcnt;
    bit          m_glitch;
    bit          m_partial;
    bit          m_overrun;

    function automatic void model_reset();
        m_synced  = 1'b0;
        m_bits    = 0;
        m_word    = '0;
        m_pcnt    = 0;
        m_glitch  = 1'b0;
        m_partial = 1'b0;
        m_overrun = 1'b0;
        exp_px_q.delete();
        exp_idx_q.delete();
        exp_fr_q.delete();
    endfunction

    function automatic void model_pulse(input int w);
        if (!m_synced) return;
        if (w < T_MIN || w > T_MAX) begin
            m_glitch = 1'b1;
            m_synced = 1'b0;
            m_bits   = 0;
            m_pcnt   = 0;
            return;
        end
        m_word = (m_word << 1) | ((w >= T_TH) ? 24'd1 : 24'd0);
        m_bits++;
        if (m_bits == 24) begin
            m_bits = 0;
            if (m_pcnt < LEDS) begin
                exp_px_q.push_back(m_word);
                exp_idx_q.push_back(m_pcnt);
                m_pcnt++;
            end else begin
                m_overrun = 1'b1;
            end
        end
    endfunction

    function automatic void model_low(input int n);
        if (n <= T_RST) return;
        if (!m_synced) begin
            m_synced = 1'b1;
        end else if (m_bits != 0 || m_pcnt != 0) begin
            exp_fr_q.push_back(m_pcnt);
            if (m_bits != 0) m_partial = 1'b1;
            m_bits = 0;
            m_pcnt = 0;
        end
    endfunction

    // Compare process: every strobe must match the oldest prediction.
    int          px_seen = 0;
    int          fr_seen = 0;
    logic [23:0] last_px = '0;
    int          last_idx = -1;
    int          last_fr = -1;

    always @(negedge clk) begin
        if (reset_n && pixel_valid) begin
            px_seen++;
            last_px  = pixel_data;
            last_idx = int'(pixel_idx);
            check("px_predicted", 32'(exp_px_q.size() != 0), 32'd1);
            if (exp_px_q.size() != 0) begin
                check("px_data", 32'(pixel_data), 32'(exp_px_q.pop_front()));
                check("px_idx", 32'(pixel_idx), 32'(exp_idx_q.pop_front()));
            end
        end
        if (reset_n && frame_done) begin
            fr_seen++;
            last_fr = int'(frame_px);
            check("frame_predicted", 32'(exp_fr_q.size() != 0), 32'd1);
            if (exp_fr_q.size() != 0)
                check("frame_px", 32'(frame_px), 32'(exp_fr_q.pop_front()));
        end
    end

    // Stimulus helpers; each starts and ends on a falling clk edge.
    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        model_pulse(hi);
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        pulse(b ? 62 : 12, 2);
    endtask

    task automatic send_bits(input logic [23:0] w, input int hi_idx, input int lo_idx);
        for (int i = hi_idx; i >= lo_idx; i--) send_bit(w[i]);
    endtask

    task automatic hold_low(input int n);
        din = 1'b0;
        model_low(n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr   = 1'b0;
        m_glitch  = 1'b0;
        m_partial = 1'b0;
        m_overrun = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_glitch"}, 32'(err_glitch), 32'(m_glitch));
        check({tag, "_partial"}, 32'(err_partial), 32'(m_partial));
        check({tag, "_overrun"}, 32'(err_overrun), 32'(m_overrun));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int px0;
        int fr0;
        logic [23:0] spec_px;
        int bnd_w[4];

        reset_n = 1'b0;
        din     = 1'b0;
        err_clr = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_errs", 32'({err_glitch, err_partial, err_overrun}), 32'd0);
        check("rst_pixel_data", 32'(pixel_data), 32'd0);
        check("rst_frame_px", 32'(frame_px), 32'd0);
        reset_n = 1'b1;

        // 1: first pixel after a long idle, spec-nominal T0H/T1H with 125-cycle bits
        hold_low(6000);
        spec_px = 24'hFF0080;
        for (int i = 23; i >= 0; i--) pulse(spec_px[i] ? 80 : 40, spec_px[i] ? 45 : 85);
        settle();
        check("t1_px_count", 32'(px_seen), 32'd1);
        check("t1_px_data", 32'(last_px), 32'hFF0080);
        check("t1_px_idx", 32'(last_idx), 32'd0);
        check("t1_busy_in_frame", 32'(busy), 32'd1);
        hold_low(LATCH_LOW);
        check("t1_frame_count", 32'(fr_seen), 32'd1);
        check("t1_frame_px", 32'(last_fr), 32'd1);
        check("t1_busy_after_latch", 32'(busy), 32'd0);

        // 2: full frame of 52 pixels
        px0 = px_seen;
        for (int p = 0; p < LEDS; p++) send_bits({2'b10, 6'(p), 16'h0000}, 23, 0);
        hold_low(LATCH_LOW);
        check("t2_px_count", 32'(px_seen - px0), 32'd52);
        check("t2_last_idx", 32'(last_idx), 32'd51);
        check("t2_frame_px", 32'(last_fr), 32'd52);
        check_flags("t2");

        // Width boundaries: 60 -> 1, 59 -> 0, 10 -> 0 (shortest legal), 200 -> 1 (longest legal)
        bnd_w = '{60, 59, 10, 200};
        foreach (bnd_w[k]) pulse(bnd_w[k], 2);
        send_bits(24'h05A5A5, 19, 0);
        settle();
        check("bnd_px_data", 32'(last_px), 32'h95A5A5);
        check_flags("bnd");
        hold_low(LATCH_LOW);

        // 3: 5-cycle glitch mid-pixel, then resync and a clean pixel
        px0 = px_seen;
        fr0 = fr_seen;
        send_bits(24'hABCDEF, 23, 14);
        pulse(5, 20);
        send_bits(24'hABCDEF, 13, 0);
        hold_low(LATCH_LOW);
        check("t3_glitch", 32'(err_glitch), 32'd1);
        check("t3_no_px", 32'(px_seen - px0), 32'd0);
        check("t3_no_frame", 32'(fr_seen - fr0), 32'd0);
        send_bits(24'h123456, 23, 0);
        hold_low(LATCH_LOW);
        check("t3_px_data", 32'(last_px), 32'h123456);
        check("t3_px_idx", 32'(last_idx), 32'd0);
        check_flags("t3");

        // Stuck-high pulse longer than T_MAX_HIGH
        pulse_clr();
        check("stuck_clr", 32'(err_glitch), 32'd0);
        pulse(250, 20);
        hold_low(LATCH_LOW);
        check("stuck_glitch", 32'(err_glitch), 32'd1);
        check_flags("stuck");
        pulse_clr();

        // 4: 12 bits then latch -> partial error, frame of 0 full pixels
        fr0 = fr_seen;
        send_bits(24'hF0F0F0, 23, 12);
        hold_low(LATCH_LOW);
        check("t4_partial", 32'(err_partial), 32'd1);
        check("t4_frame_count", 32'(fr_seen - fr0), 32'd1);
        check("t4_frame_px", 32'(last_fr), 32'd0);
        check_flags("t4");

        // 5: 53 pixels -> overrun on the last, frame_px saturates at 52
        pulse_clr();
        check_flags("t5_clr");
        px0 = px_seen;
        for (int p = 0; p < LEDS + 1; p++) send_bits({2'b01, 6'(p), 16'h0000}, 23, 0);
        hold_low(LATCH_LOW);
        check("t5_px_count", 32'(px_seen - px0), 32'd52);
        check("t5_overrun", 32'(err_overrun), 32'd1);
        check("t5_frame_px", 32'(last_fr), 32'd52);
        check_flags("t5");
        pulse_clr();
        check("t5_cleared", 32'({err_glitch, err_partial, err_overrun}), 32'd0);

        // 6: reset mid-pixel; nothing decodes until a full latch-length low
        px0 = px_seen;
        fr0 = fr_seen;
        send_bits(24'h3C3C3C, 23, 14);
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        send_bits(24'h3C3C3C, 13, 0);
        settle();
        check("t6_no_px", 32'(px_seen - px0), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        hold_low(LATCH_LOW);
        check("t6_no_frame", 32'(fr_seen - fr0), 32'd0);
        send_bits(24'hC35A3C, 23, 0);
        hold_low(LATCH_LOW);
        check("t6_px_data", 32'(last_px), 32'hC35A3C);
        check("t6_px_idx", 32'(last_idx), 32'd0);
        check("t6_frame_px", 32'(last_fr), 32'd1);
        check_flags("t6");

        check("end_px_pending", 32'(exp_px_q.size()), 32'd0);
        check("end_fr_pending", 32'(exp_fr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
